// File: rtl/exec_commit_arbiter.sv
// Commit-side receiver: arbitrates NUM_SRC execute result buses onto WB_PORTS
// registered writeback lanes using a rotating-priority scan.

package exec_commit_pkg;
  localparam int PHY_W = 6;
  localparam int ROB_W = 4;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
  } exception_t;

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic [3:0]       rf_we;
    logic [PHY_W-1:0] phy_dest;
    logic [31:0]      result;
    logic             is_store_op;
    exception_t       exception;
  } execute_to_commit_bus_t;
endpackage

module exec_commit_arbiter
  import exec_commit_pkg::*;
#(
  parameter int NUM_SRC  = 5,
  parameter int WB_PORTS = 2,
  parameter int PHY_W    = exec_commit_pkg::PHY_W,
  parameter int ROB_W    = exec_commit_pkg::ROB_W,
  localparam int SID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  execute_to_commit_bus_t [NUM_SRC-1:0]   src_bus,
  output logic [NUM_SRC-1:0]                     cs_allowin,
  output logic [WB_PORTS-1:0]                    wb_valid,
  output logic [WB_PORTS-1:0][ROB_W-1:0]         wb_rob_entry,
  output logic [WB_PORTS-1:0][3:0]               wb_rf_we,
  output logic [WB_PORTS-1:0][PHY_W-1:0]         wb_phy_dest,
  output logic [WB_PORTS-1:0][31:0]              wb_result,
  output logic [WB_PORTS-1:0]                    wb_is_store,
  output exception_t [WB_PORTS-1:0]              wb_exception,
  output logic [WB_PORTS-1:0][SID_W-1:0]         wb_src_id
);

  logic                           kill;
  logic [SID_W-1:0]               rr_ptr_q;
  logic [SID_W-1:0]               rr_ptr_d;
  logic [NUM_SRC-1:0]             grant;
  logic [WB_PORTS-1:0]            lane_vld;
  logic [WB_PORTS-1:0][SID_W-1:0] lane_sel;

  assign kill = reset | flush;

  // Reduce a value in [0, 2*NUM_SRC) back into the source index range.
  function automatic logic [SID_W-1:0] wrap_idx(input logic [SID_W:0] v);
    logic [SID_W:0] r;
    r = v;
    if (v >= (SID_W+1)'(NUM_SRC)) begin
      r = v - (SID_W+1)'(NUM_SRC);
    end
    return r[SID_W-1:0];
  endfunction

  // Rotating scan: the n-th valid source seen from rr_ptr lands on lane n.
  always_comb begin
    logic [SID_W-1:0] idx;
    logic [SID_W-1:0] last;
    int               rank;
    grant    = '0;
    lane_vld = '0;
    lane_sel = '0;
    last     = rr_ptr_q;
    rank     = 0;
    idx      = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = wrap_idx({1'b0, rr_ptr_q} + (SID_W+1)'(j));
      if (!kill && src_valid[idx] && (rank < WB_PORTS)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < WB_PORTS; k++) begin
          if (rank == k) begin
            lane_vld[k] = 1'b1;
            lane_sel[k] = idx;
          end
        end
        last = idx;
        rank = rank + 1;
      end
    end
    rr_ptr_d = (|grant) ? wrap_idx({1'b0, last} + (SID_W+1)'(1)) : rr_ptr_q;
  end

  // Units clear themselves on flush/reset, so let every one advance.
  assign cs_allowin = kill ? '1 : (grant | ~src_valid);

  always_ff @(posedge clk) begin
    if (kill) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_lane
      execute_to_commit_bus_t lane_bus_q;
      logic                   lane_vld_q;
      logic [SID_W-1:0]       lane_sid_q;

      // Idle lanes keep stale data; consumers qualify with wb_valid.
      always_ff @(posedge clk) begin
        if (kill) begin
          lane_vld_q <= 1'b0;
          lane_bus_q <= '0;
          lane_sid_q <= '0;
        end else begin
          lane_vld_q <= lane_vld[gi];
          if (lane_vld[gi]) begin
            lane_bus_q <= src_bus[lane_sel[gi]];
            lane_sid_q <= lane_sel[gi];
          end
        end
      end

      assign wb_valid[gi]     = lane_vld_q;
      assign wb_rob_entry[gi] = lane_bus_q.rob_entry;
      assign wb_rf_we[gi]     = lane_bus_q.rf_we;
      assign wb_phy_dest[gi]  = lane_bus_q.phy_dest;
      assign wb_result[gi]    = lane_bus_q.result;
      assign wb_is_store[gi]  = lane_bus_q.is_store_op;
      assign wb_exception[gi] = lane_bus_q.exception;
      assign wb_src_id[gi]    = lane_sid_q;
    end
  endgenerate

endmodule

// File: doc/exec_commit_arbiter.md
Name: exec_commit_arbiter

Overview:
- Receiving end of the execute-to-commit interface.
- Collects result buses from NUM_SRC execute units (ALU0, ALU1, BRU, LSU, MDU) and grants at most WB_PORTS of them per cycle through a rotating-priority arbiter.
- Returns a per-source allowin, which is the cs_allowin each unit uses in its own allowin computation.
- Registers the granted results onto WB_PORTS writeback lanes that drive ROB completion and the physical register file write ports.

Parameters:
- NUM_SRC, 5, number of execute units feeding commit.
- WB_PORTS, 2, writeback lanes per cycle; legal range 1..NUM_SRC.
- PHY_W, 6, physical register address width; must equal the reg_addr_t width.
- ROB_W, 4, ROB entry index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush, synchronous
- src_valid  in  NUM_SRC  per-unit result valid (each unit's to_valid)
- src_bus  in  NUM_SRC x execute_to_commit_bus_t  per-unit result bus
- cs_allowin  out  NUM_SRC  per-unit grant; the unit may advance this cycle
- wb_valid  out  WB_PORTS  lane carries a completed result
- wb_rob_entry  out  WB_PORTS x ROB_W  ROB entry to mark complete
- wb_rf_we  out  WB_PORTS x 4  byte write enables to the PRF
- wb_phy_dest  out  WB_PORTS x PHY_W  PRF write address
- wb_result  out  WB_PORTS x 32  write data
- wb_is_store  out  WB_PORTS  store marker forwarded to the ROB
- wb_exception  out  WB_PORTS x exception_t  exception info forwarded to the ROB
- wb_src_id  out  WB_PORTS x clog2(NUM_SRC)  granting source, for debug and verification

Behaviour:
- Reset or flush:
  - wb_valid = 0 and all wb_* data = 0.
  - rr_ptr = 0.
  - cs_allowin is combinational, so it is fully determined by the current inputs.
- Arbitration is combinational within the cycle:
  - Scan sources starting at rr_ptr, modulo NUM_SRC.
  - Lane 0 takes the first src_valid found; lane 1 takes the next; and so on up to WB_PORTS.
  - cs_allowin[i] = granted[i] OR NOT src_valid[i]. An idle unit is always allowed in, which matches the unit-side rule allowin = cs_allowin || !valid.
  - A valid source that is not granted sees cs_allowin = 0 and must hold its bus stable.
  - During flush, cs_allowin = all ones; units clear themselves on flush.
- Writeback registration:
  - On the clock edge, lane k registers the bus of its granted source, with wb_valid[k] = 1.
  - Lanes with no grant register wb_valid[k] = 0 and their data fields hold their previous values. Consumers must qualify every field with wb_valid.
  - Latency from a granted source to the wb_* outputs is exactly 1 cycle.
  - The ROB and PRF always accept; there is no backpressure on the lanes.
- Lane packing: lanes fill in order. If lane k is invalid, every lane above k is invalid.
- Pointer update: if any grant occurs, rr_ptr becomes (index of the last granted source + 1) mod NUM_SRC. With no grants, rr_ptr holds.
- Fairness: any continuously valid source is granted within ceil(NUM_SRC/WB_PORTS) cycles (3 cycles at the defaults).
- wb_rf_we is forwarded verbatim from the source bus. A source with rf_we = 0 still completes in the ROB.
- Flush asserted in the same cycle as valid sources: nothing is granted into the lanes, the registered outputs clear, and rr_ptr resets.
- Reset asserted mid-stream: same effect as flush.
- Arbitration never duplicates a source across lanes and never drops a granted source.

Test Plan:
1. Reset, then src_valid = 00001 with ALU0 result 0x12345678, phy 5, rob 3, rf_we 4'hF.
   Required: cs_allowin = 11111 in that cycle; next cycle wb_valid = 01, lane0 carries rob 3, phy 5, 0x12345678, wb_src_id 0.
2. src_valid = 11111 held for 3 cycles, all units stalling, rr_ptr = 0.
   Required grants: {0,1}, then {2,3}, then {4,0}.
   Required cs_allowin: 00011, 01100, 10001.
   Required rr_ptr after each cycle: 2, 4, 1.
3. src_valid = 10100, rr_ptr = 3.
   Required: lane0 = source 4, lane1 = source 2; cs_allowin = 11111 (both valid sources granted); rr_ptr becomes 3.
4. Flush asserted with src_valid = 11111.
   Required: cs_allowin = 11111; next cycle wb_valid = 00 and rr_ptr = 0.
   Then src_valid = 00010 gives wb_valid = 01 with wb_src_id = 1.
5. A source bus with rf_we = 0 and is_store_op = 1.
   Required: wb_valid asserted, wb_rf_we = 0, wb_is_store = 1; no PRF write occurs.
6. Random valid traffic for 10k cycles.
   Scoreboard checks: each granted unit transaction appears exactly once on a lane, in order per source, with 1-cycle latency, and no valid source waits more than 3 cycles.
